// File: rtl/weak_bus_arbiter_if.sv
// weak_bus_arbiter_if
//   One weakcore memory bus link (request/acknowledge handshake).
//   master modport: the side that issues requests (drives req/addr/out/wr/wr_mask,
//                   receives in/ack).
//   slave modport : the side that serves requests (receives req/addr/out/wr/wr_mask,
//                   drives in/ack).
interface weak_bus_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] out;
    logic        wr;
    logic [3:0]  wr_mask;
    logic [31:0] in;
    logic        ack;

    modport master (output req, addr, out, wr, wr_mask, input in, ack);
    modport slave  (input req, addr, out, wr, wr_mask, output in, ack);
endinterface

// File: rtl/weak_bus_arbiter.sv
// weak_bus_arbiter
//   Two-master / one-slave arbiter for the weakcore memory bus. Round-robin grant,
//   the winner keeps the slave until it acks, and a watchdog force-completes a
//   transfer the slave never acks (error data back to the master, sticky fault flag).
// Ports:
//   clk        : clock, all state on posedge
//   rst        : asynchronous active-low reset
//   m0, m1     : master links (slave modport of the bus interface)
//   s          : slave link (master modport of the bus interface)
//   err_flag   : sticky watchdog timeout flag
//   err_master : master that owned the last timed-out transfer
//   err_clr    : synchronous clear of err_flag
module weak_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_W     = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    weak_bus_arbiter_if.slave     m0,
    weak_bus_arbiter_if.slave     m1,
    weak_bus_arbiter_if.master    s,
    output logic                  err_flag,
    output logic                  err_master,
    input  logic                  err_clr
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit              WDOG_EN = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_flag_q, err_flag_d;
    logic            err_master_q, err_master_d;

    logic            busy;
    logic            timeout_hit;
    logic            done;
    logic            ack0, ack1;
    logic [31:0]     rdata;

    assign busy = (state_q == BUSY);

    // Slave ack in the last watchdog cycle wins over the forced completion.
    assign timeout_hit = WDOG_EN && busy && !s.ack && (cnt_q == TO_LAST);
    assign done        = busy && (s.ack || timeout_hit);
    assign rdata       = s.ack ? s.in : ERR_DATA;

    // Slave side follows the owner's inputs combinationally; zero while idle.
    assign s.req     = busy;
    assign s.addr    = busy ? (owner_q ? m1.addr    : m0.addr)    : 32'h0;
    assign s.out     = busy ? (owner_q ? m1.out     : m0.out)     : 32'h0;
    assign s.wr      = busy ? (owner_q ? m1.wr      : m0.wr)      : 1'b0;
    assign s.wr_mask = busy ? (owner_q ? m1.wr_mask : m0.wr_mask) : 4'h0;

    assign ack0  = done && !owner_q;
    assign ack1  = done &&  owner_q;
    assign m0.ack = ack0;
    assign m1.ack = ack1;
    assign m0.in  = ack0 ? rdata : 32'h0;
    assign m1.in  = ack1 ? rdata : 32'h0;

    assign err_flag   = err_flag_q;
    assign err_master = err_master_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        err_flag_d   = err_flag_q;
        err_master_d = err_master_q;

        case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    state_d = BUSY;
                    // On a tie the master that did not go last wins.
                    owner_d = (m0.req && m1.req) ? ~last_q : m1.req;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as err_clr keeps the flag set.
        if (timeout_hit) begin
            err_flag_d   = 1'b1;
            err_master_d = owner_q;
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            err_flag_q   <= 1'b0;
            err_master_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            err_flag_q   <= err_flag_d;
            err_master_q <= err_master_d;
        end
    end

endmodule

// File: tb/tb_weak_bus_arbiter.sv
// tb_weak_bus_arbiter
//   Directed table-driven bench for weak_bus_arbiter (watchdog TIMEOUT = 4),
//   plus hand-written sequences for timeout, ack-at-boundary and reset mid-transfer.
module tb_weak_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0204;

    logic clk = 1'b0;
    logic rst;
    logic err_flag, err_master, err_clr;

    weak_bus_arbiter_if m0 ();
    weak_bus_arbiter_if m1 ();
    weak_bus_arbiter_if s ();

    weak_bus_arbiter #(.TIMEOUT(4), .TO_W(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0),
        .m1         (m1),
        .s          (s),
        .err_flag   (err_flag),
        .err_master (err_master),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          dly;
        logic [31:0] sin;
        logic        owner;
    } vec_t;

    vec_t        vecs [7];
    vec_t        v;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr, exp_out;
    logic [3:0]  exp_mask;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        //            r0    r1    wr    wdata          mask     dly sin            owner
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b1111, 2, 32'h1234_5678, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b1111, 0, 32'h0000_0011, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b1111, 0, 32'h0000_0022, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b1111, 0, 32'h0000_0033, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hAABB_CCDD, 4'b1100, 1, 32'h0000_0055, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0F0F_0F0F, 4'b0011, 0, 32'h0000_0066, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'b0001, 2, 32'hCAFE_F00D, 1'b1};

        // Reset held with both masters requesting: everything stays quiet.
        rst = 1'b0; err_clr = 1'b0;
        s.ack = 1'b0; s.in = 32'h0;
        m0.req = 1'b1; m0.addr = A0; m0.out = 32'h0; m0.wr = 1'b0; m0.wr_mask = 4'h0;
        m1.req = 1'b1; m1.addr = A1; m1.out = 32'h0; m1.wr = 1'b0; m1.wr_mask = 4'h0;
        step(); step();
        chk1 ("rst_s_req",      s.req,      1'b0);
        chk32("rst_s_addr",     s.addr,     32'h0);
        chk1 ("rst_m0_ack",     m0.ack,     1'b0);
        chk1 ("rst_m1_ack",     m1.ack,     1'b0);
        chk1 ("rst_err_flag",   err_flag,   1'b0);
        chk1 ("rst_err_master", err_master, 1'b0);
        m0.req = 1'b0; m1.req = 1'b0;
        rst = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            m0.req = v.r0;   m1.req = v.r1;
            m0.wr = v.wr;    m1.wr = v.wr;
            m0.out = ~v.wdata; m1.out = v.wdata;
            m0.wr_mask = ~v.mask; m1.wr_mask = v.mask;
            #1;
            chk1("idle_s_req", s.req, 1'b0);
            step();
            exp_addr = v.owner ? A1 : A0;
            exp_out  = v.owner ? v.wdata : ~v.wdata;
            exp_mask = v.owner ? v.mask : ~v.mask;
            chk1 ("grant_s_req", s.req, 1'b1);
            chk32("grant_s_addr", s.addr, exp_addr);
            chk32("grant_s_out", s.out, exp_out);
            chk1 ("grant_s_wr", s.wr, v.wr);
            chk32("grant_s_mask", {28'h0, s.wr_mask}, {28'h0, exp_mask});
            for (int d = 0; d < v.dly; d++) begin
                chk1("wait_no_ack", m0.ack | m1.ack, 1'b0);
                step();
                chk32("hold_s_addr", s.addr, exp_addr);
                chk32("hold_s_out", s.out, exp_out);
                chk1 ("hold_s_wr", s.wr, v.wr);
                chk32("hold_s_mask", {28'h0, s.wr_mask}, {28'h0, exp_mask});
            end
            s.ack = 1'b1; s.in = v.sin;
            #1;
            chk1 ("ack_m0", m0.ack, ~v.owner);
            chk1 ("ack_m1", m1.ack, v.owner);
            chk32("ack_m0_in", m0.in, v.owner ? 32'h0 : v.sin);
            chk32("ack_m1_in", m1.in, v.owner ? v.sin : 32'h0);
            step();
            s.ack = 1'b0; s.in = 32'h0;
            m0.req = 1'b0; m1.req = 1'b0;
            #1;
            chk1("post_ack_idle", s.req, 1'b0);
            chk1("post_ack_no_ack", m0.ack | m1.ack, 1'b0);
        end

        // Watchdog timeout on an m1 read: forced ack in the 4th busy cycle.
        m1.req = 1'b1; m1.wr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c < 4) chk1("to_no_ack_early", m1.ack, 1'b0);
        end
        chk1 ("to_m1_ack", m1.ack, 1'b1);
        chk32("to_m1_in", m1.in, 32'hDEADBEEF);
        chk1 ("to_s_req_held", s.req, 1'b1);
        chk1 ("to_flag_not_yet", err_flag, 1'b0);
        m1.req = 1'b0;
        step();
        chk1("to_err_flag", err_flag, 1'b1);
        chk1("to_err_master", err_master, 1'b1);
        chk1("to_idle", s.req, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk1("to_err_clr", err_flag, 1'b0);

        // Timeout on m0 with err_clr held: setting wins.
        m0.req = 1'b1; m0.wr = 1'b0; err_clr = 1'b1;
        repeat (4) step();
        chk1("to0_m0_ack", m0.ack, 1'b1);
        m0.req = 1'b0;
        step();
        chk1("to0_set_wins", err_flag, 1'b1);
        chk1("to0_err_master", err_master, 1'b0);
        step();
        err_clr = 1'b0;
        chk1("to0_cleared", err_flag, 1'b0);

        // Slave ack exactly in the last watchdog cycle: normal completion.
        m0.req = 1'b1;
        repeat (3) step();
        chk1("bnd_no_ack_early", m0.ack, 1'b0);
        step();
        s.ack = 1'b1; s.in = 32'h1;
        #1;
        chk1 ("bnd_m0_ack", m0.ack, 1'b1);
        chk32("bnd_m0_in", m0.in, 32'h1);
        step();
        s.ack = 1'b0; s.in = 32'h0; m0.req = 1'b0;
        chk1("bnd_no_err", err_flag, 1'b0);
        chk1("bnd_idle", s.req, 1'b0);

        // Reset mid-transfer: m1 holds the grant (m0 went last), reset must drop
        // s_req without a clock edge and restore m0 tie priority.
        m0.req = 1'b1; m1.req = 1'b1;
        step();
        chk1 ("mid_busy", s.req, 1'b1);
        chk32("mid_owner_m1", s.addr, A1);
        #2 rst = 1'b0;
        #1;
        chk1 ("mid_rst_s_req", s.req, 1'b0);
        chk1 ("mid_rst_m1_ack", m1.ack, 1'b0);
        #3 rst = 1'b1;
        step();
        chk1 ("after_rst_busy", s.req, 1'b1);
        chk32("after_rst_owner_m0", s.addr, A0);
        s.ack = 1'b1; s.in = 32'h77;
        #1;
        chk1("after_rst_m0_ack", m0.ack, 1'b1);
        step();
        s.ack = 1'b0; m0.req = 1'b0; m1.req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weak_bus_arbiter.md
Name: weak_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the weakcore memory bus (req/ack, addr, out, in, wr, wr_mask).
- Lets the RV32I core and a second master (debug loader/DMA) share one memory port.
- Uses round-robin grant with a transaction lock until slave ack.
- A watchdog completes any slave transfer that never acks, returns error data to the master, and records the fault.

Parameters:
TIMEOUT, 255, max cycles in BUSY without s_ack before forced completion; 0 disables watchdog
TO_W, 16, watchdog counter width; TIMEOUT < 2^TO_W
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-low reset
mN_req  input  1  master N (N=0,1) request; held with addr/out/wr/mask stable until mN_ack
mN_addr  input  32  master N word address (bits[1:0] already zero)
mN_out  input  32  master N write data
mN_wr  input  1  master N write (1) / read (0)
mN_wr_mask  input  4  master N byte enables
mN_in  output  32  read data to master N, valid in mN_ack cycle
mN_ack  output  1  single-cycle completion to master N
s_req  output  1  slave request
s_addr  output  32  slave address
s_out  output  32  slave write data
s_wr  output  1  slave write
s_wr_mask  output  4  slave byte enables
s_in  input  32  slave read data, valid with s_ack
s_ack  input  1  slave completion
err_flag  output  1  sticky timeout flag
err_master  output  1  master that owned the last timed-out transfer
err_clr  input  1  synchronous clear of err_flag

Behaviour:
- Reset (rst=0, async): state=IDLE, owner=0, last=1 (m0 wins first tie), counter=0, err_flag=0, err_master=0. All outputs 0 while reset is held.
- States:
  - IDLE: s_req=0, all s_* outputs 0, mN_ack=0.
  - If any mN_req is high: go to BUSY, owner=winner.
    - Only one request: that master wins.
    - Both request: the master != last wins.
  - Grant is registered: the first s_req comes 1 cycle after mN_req rises.
- BUSY:
  - s_req=1; s_addr/s_out/s_wr/s_wr_mask come combinationally from the owner's inputs.
  - On s_ack: m{owner}_ack=1 and m{owner}_in=s_in in the same cycle. Then last<=owner, counter<=0, state<=IDLE.
  - Next grant is earliest the following cycle, so each transfer takes ≥1 IDLE cycle. The other master cannot starve: it wins the next tie.
- Non-owner ack: always 0. mN_in is 0 whenever mN_ack=0.
- Watchdog: counter increments each BUSY cycle without s_ack.
  - When TIMEOUT≠0 and counter==TIMEOUT-1 with no s_ack: that cycle m{owner}_ack=1, m{owner}_in=ERR_DATA, s_req stays 1 that cycle.
  - Then err_flag<=1, err_master<=owner, last<=owner, state<=IDLE.
  - If s_ack arrives in the same cycle, it takes precedence: normal completion, no error.
- err_clr=1 clears err_flag next edge. If a timeout occurs in the same cycle, set wins.
- Writes follow the same rules; s_in is ignored for writes, but m_in still mirrors s_in in the ack cycle.
- Master drops req while BUSY (protocol violation): the transfer continues and ack is still delivered. The arbiter does not abort.
- Reset mid-transfer: everything returns to IDLE immediately and s_req drops asynchronously. The slave must tolerate an abandoned request.
- No combinational path from mN_req to s_req. There is a combinational path from s_ack/s_in to mN_ack/mN_in.

Test Plan:
- Single read:
  - Stimulus: m0_req=1, addr=0x100, wr=0; slave acks 2 cycles after s_req with s_in=0x12345678.
  - Required: s_addr=0x100 from cycle 1; m0_ack pulse with m0_in=0x12345678; m1_ack stays 0; next cycle IDLE.
- Simultaneous after reset:
  - Stimulus: m0 and m1 request together; slave acks immediately.
  - Required: grant order m0, m1, m0, m1 while both hold requests; each grant is separated by one IDLE cycle.
- Write pass-through:
  - Stimulus: m1 write, addr=0x204, out=0xAABBCCDD, mask=4'b1100.
  - Required: s_wr=1, s_out=0xAABBCCDD, s_wr_mask=4'b1100 throughout BUSY.
- Timeout (TIMEOUT=4):
  - Stimulus: m1 read; slave never acks.
  - Required: m1_ack in the 4th BUSY cycle with m1_in=0xDEADBEEF; err_flag=1 and err_master=1 next cycle; err_clr clears the flag.
- Ack at the timeout boundary:
  - Stimulus: s_ack arrives exactly in cycle TIMEOUT-1, s_in=0x1.
  - Required: m_in=0x1; err_flag stays 0.
- Reset mid-transfer:
  - Stimulus: drop rst during BUSY.
  - Required: s_req=0 immediately without a clock edge; after release, both requesting gives an m0 grant first.
